// File: rtl/aabb_scheduler.sv
// Dispatches bounding-box jobs to sphere/box/capsule engines and collects their results.
// Latency: eng_start one cycle after acceptance; result presented two cycles after the engine completes.
// Backpressure: job_ready low while the target engine is occupied; results held stable until res_ready.
//
// Ports:
//   CLK, rst                  clock, asynchronous active-low reset
//   job_valid/job_ready       job offer handshake; job_type selects engine (3 = illegal, dropped)
//   job_id                    tag carried through to the result
//   eng_start / eng_done      per-engine start pulse out, completion pulse in
//   res_valid/res_ready       result handshake; res_type/res_id/res_err describe the result
//   bad_type, bad_cnt         illegal-job pulse and saturating drop counter
//   busy                      any engine not idle
module aabb_scheduler #(
    parameter int ID_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            job_valid,
    output logic            job_ready,
    input  logic [1:0]      job_type,
    input  logic [ID_W-1:0] job_id,
    output logic [2:0]      eng_start,
    input  logic [2:0]      eng_done,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [1:0]      res_type,
    output logic [ID_W-1:0] res_id,
    output logic            res_err,
    output logic            bad_type,
    output logic [7:0]      bad_cnt,
    output logic            busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_PEND} eng_st_t;

    // Age value at which the next BUSY cycle would make age equal TIMEOUT,
    // so an engine spends exactly TIMEOUT cycles in BUSY before aborting.
    localparam logic [15:0] AGE_LAST = 16'(TIMEOUT - 1);

    eng_st_t         state_q   [3];
    eng_st_t         state_nxt [3];
    logic [ID_W-1:0] id_q      [3];
    logic [ID_W-1:0] id_nxt    [3];
    logic [15:0]     age_q     [3];
    logic [15:0]     age_nxt   [3];
    logic [2:0]      err_q;
    logic [2:0]      err_nxt;

    logic            accept;
    logic            accept_bad;
    logic [2:0]      acc_vec;
    logic [2:0]      rel_vec;
    logic [1:0]      ptr_q;
    logic            pick_vld;
    logic [1:0]      pick_idx;
    logic [2:0]      cand;

    always_comb begin
        job_ready = 1'b1;
        case (job_type)
            2'd0:    job_ready = (state_q[0] == ST_IDLE);
            2'd1:    job_ready = (state_q[1] == ST_IDLE);
            2'd2:    job_ready = (state_q[2] == ST_IDLE);
            default: job_ready = 1'b1;
        endcase
    end

    assign accept     = job_valid && job_ready;
    assign accept_bad = accept && (job_type == 2'd3);

    always_comb begin
        acc_vec = 3'b000;
        rel_vec = 3'b000;
        for (int e = 0; e < 3; e++) begin
            acc_vec[e] = accept && (job_type == 2'(e));
            rel_vec[e] = res_valid && res_ready && (res_type == 2'(e));
        end
    end

    // Per-engine FSM next-state logic
    always_comb begin
        for (int e = 0; e < 3; e++) begin
            state_nxt[e] = state_q[e];
            id_nxt[e]    = id_q[e];
            err_nxt[e]   = err_q[e];
            age_nxt[e]   = age_q[e];
            case (state_q[e])
                ST_IDLE: begin
                    if (acc_vec[e]) begin
                        state_nxt[e] = ST_BUSY;
                        id_nxt[e]    = job_id;
                        err_nxt[e]   = 1'b0;
                        age_nxt[e]   = 16'd0;
                    end
                end
                ST_BUSY: begin
                    age_nxt[e] = age_q[e] + 16'd1;
                    // Completion takes precedence over a coincident timeout.
                    if (eng_done[e]) begin
                        state_nxt[e] = ST_PEND;
                        err_nxt[e]   = 1'b0;
                    end else if (age_q[e] == AGE_LAST) begin
                        state_nxt[e] = ST_PEND;
                        err_nxt[e]   = 1'b1;
                    end
                end
                ST_PEND: begin
                    if (rel_vec[e]) begin
                        state_nxt[e] = ST_IDLE;
                    end
                end
                default: state_nxt[e] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < 3; e++) begin
                state_q[e] <= ST_IDLE;
                id_q[e]    <= '0;
                age_q[e]   <= 16'd0;
            end
            err_q <= 3'b000;
        end else begin
            for (int e = 0; e < 3; e++) begin
                state_q[e] <= state_nxt[e];
                id_q[e]    <= id_nxt[e];
                age_q[e]   <= age_nxt[e];
            end
            err_q <= err_nxt;
        end
    end

    // Round-robin search over PEND engines, starting at ptr_q.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 2'd0;
        cand     = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!pick_vld && (state_q[cand[1:0]] == ST_PEND)) begin
                pick_vld = 1'b1;
                pick_idx = cand[1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            eng_start <= 3'b000;
            res_valid <= 1'b0;
            res_type  <= 2'd0;
            res_id    <= '0;
            res_err   <= 1'b0;
            bad_type  <= 1'b0;
            bad_cnt   <= 8'd0;
            ptr_q     <= 2'd0;
        end else begin
            eng_start <= acc_vec;
            bad_type  <= accept_bad;
            if (accept_bad && (bad_cnt != 8'hFF)) begin
                bad_cnt <= bad_cnt + 8'd1;
            end
            // Selection is only made while no result is presented, so the
            // presented result cannot change until it is consumed.
            if (res_valid) begin
                if (res_ready) begin
                    res_valid <= 1'b0;
                end
            end else if (pick_vld) begin
                res_valid <= 1'b1;
                res_type  <= pick_idx;
                res_id    <= id_q[pick_idx];
                res_err   <= err_q[pick_idx];
                ptr_q     <= (pick_idx == 2'd2) ? 2'd0 : pick_idx + 2'd1;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int e = 0; e < 3; e++) begin
            busy = busy | (state_q[e] != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_aabb_scheduler.sv
module tb_aabb_scheduler;

    localparam int ID_W    = 8;
    localparam int TIMEOUT = 8;

    logic            CLK = 1'b0;
    logic            rst;
    logic            job_valid;
    logic            job_ready;
    logic [1:0]      job_type;
    logic [ID_W-1:0] job_id;
    logic [2:0]      eng_start;
    logic [2:0]      eng_done;
    logic            res_valid;
    logic            res_ready;
    logic [1:0]      res_type;
    logic [ID_W-1:0] res_id;
    logic            res_err;
    logic            bad_type;
    logic [7:0]      bad_cnt;
    logic            busy;

    always #5 CLK = ~CLK;

    aabb_scheduler #(.ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_type(job_type), .job_id(job_id),
        .eng_start(eng_start), .eng_done(eng_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_type(res_type),
        .res_id(res_id), .res_err(res_err),
        .bad_type(bad_type), .bad_cnt(bad_cnt), .busy(busy)
    );

    typedef struct packed {
        logic [1:0]      t;
        logic [ID_W-1:0] id;
        logic            err;
    } res_t;

    res_t exp_q[$];
    int   vectors   = 0;
    int   errors    = 0;
    int   start_cnt = 0;
    int   bad_seen  = 0;
    int   snap_start;
    int   snap_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic cyc();
        res_t e;
        @(negedge CLK);
        start_cnt += $countones(eng_start);
        bad_seen  += int'(bad_type);
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(res_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'({res_type, res_id, res_err}), 32'(e));
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_drain(input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) cyc();
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'({eng_start, res_valid, res_type, res_id, res_err, bad_type, bad_cnt, busy}), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        job_valid = 1'b0;
        job_type  = 2'd0;
        job_id    = '0;
        eng_done  = 3'b000;
        res_ready = 1'b0;
        cycles(3);
        check_reset_outputs("reset_outputs");
        check("reset_job_ready", 32'(job_ready), 32'd1);
        rst = 1'b1;
        cyc();

        // Three engines complete together: fixed priority order on a fresh pointer.
        res_ready = 1'b1;
        job_valid = 1'b1; job_type = 2'd0; job_id = 8'h01; cyc();
        job_type = 2'd1; job_id = 8'h02; cyc();
        job_type = 2'd2; job_id = 8'h03; cyc();
        job_valid = 1'b0;
        check("three_busy", 32'(busy), 32'd1);
        job_type = 2'd1; #1;
        check("box_ready_busy", 32'(job_ready), 32'd0);
        cycles(2);
        check("three_starts", 32'(start_cnt), 32'd3);
        eng_done = 3'b111;
        exp_q.push_back('{t: 2'd0, id: 8'h01, err: 1'b0});
        exp_q.push_back('{t: 2'd1, id: 8'h02, err: 1'b0});
        exp_q.push_back('{t: 2'd2, id: 8'h03, err: 1'b0});
        cyc();
        eng_done = 3'b000;
        wait_drain(20);

        // Single sphere job, done five cycles after its start pulse.
        job_valid = 1'b1; job_type = 2'd0; job_id = 8'h11; #1;
        check("sphere_ready", 32'(job_ready), 32'd1);
        cyc();
        job_valid = 1'b0;
        check("sphere_start", 32'(eng_start), 32'b001);
        cyc();
        check("start_one_cycle", 32'(eng_start), 32'b000);
        cycles(3);
        cyc();
        eng_done = 3'b001;
        exp_q.push_back('{t: 2'd0, id: 8'h11, err: 1'b0});
        cyc();
        eng_done = 3'b000;
        check("sphere_not_yet", 32'(res_valid), 32'd0);
        cyc();
        check("sphere_result", 32'({res_valid, res_type, res_id, res_err}), 32'({1'b1, 2'd0, 8'h11, 1'b0}));
        wait_drain(5);
        cyc();
        check("sphere_valid_drop", 32'(res_valid), 32'd0);

        // Completion pulses on idle engines are ignored.
        eng_done = 3'b111;
        cyc();
        eng_done = 3'b000;
        cycles(3);
        check("idle_done_ignored", 32'({busy, res_valid}), 32'd0);

        // Box job that never completes times out after TIMEOUT busy cycles.
        res_ready = 1'b0;
        job_valid = 1'b1; job_type = 2'd1; job_id = 8'h42;
        cyc();
        job_valid = 1'b0;
        cycles(7);
        check("box_still_busy", 32'({busy, res_valid}), 32'b10);
        cyc();
        check("box_no_result_yet", 32'(res_valid), 32'd0);
        cyc();
        check("box_timeout_result", 32'({res_valid, res_type, res_id, res_err}), 32'({1'b1, 2'd1, 8'h42, 1'b1}));
        exp_q.push_back('{t: 2'd1, id: 8'h42, err: 1'b1});
        job_type = 2'd1; #1;
        check("box_ready_pend", 32'(job_ready), 32'd0);
        cycles(3);
        check("box_ready_pend_later", 32'(job_ready), 32'd0);
        res_ready = 1'b1;
        cyc();
        check("box_ready_freed", 32'(job_ready), 32'd1);
        wait_drain(5);

        // Result held under backpressure while a second sphere job waits.
        res_ready = 1'b0;
        job_valid = 1'b1; job_type = 2'd0; job_id = 8'h55;
        cyc();
        job_valid = 1'b0;
        cyc();
        eng_done = 3'b001;
        cyc();
        eng_done = 3'b000;
        cycles(2);
        exp_q.push_back('{t: 2'd0, id: 8'h55, err: 1'b0});
        job_valid = 1'b1; job_type = 2'd0; job_id = 8'h56;
        for (int i = 0; i < 10; i++) begin
            check("hold_outputs", 32'({res_valid, res_type, res_id, res_err}), 32'({1'b1, 2'd0, 8'h55, 1'b0}));
            check("hold_sphere_ready", 32'(job_ready), 32'd0);
            cyc();
        end
        // Handshake and a box acceptance on the same edge.
        job_type = 2'd1; job_id = 8'h66; res_ready = 1'b1;
        cyc();
        job_valid = 1'b0;
        check("same_cycle_start", 32'({eng_start, res_valid}), 32'({3'b010, 1'b0}));
        job_type = 2'd0; #1;
        check("sphere_ready_after_hs", 32'(job_ready), 32'd1);
        cyc();
        eng_done = 3'b010;
        exp_q.push_back('{t: 2'd1, id: 8'h66, err: 1'b0});
        cyc();
        eng_done = 3'b000;
        wait_drain(10);

        // Illegal jobs: dropped, pulsed and counted with saturation.
        snap_start = start_cnt;
        snap_bad   = bad_seen;
        job_valid = 1'b1; job_type = 2'd3; job_id = 8'hEE; #1;
        check("illegal_ready", 32'(job_ready), 32'd1);
        check("bad_before", 32'(bad_type), 32'd0);
        cyc();
        check("bad_pulse", 32'(bad_type), 32'd1);
        check("bad_cnt_one", 32'(bad_cnt), 32'd1);
        cycles(259);
        job_valid = 1'b0;
        cycles(2);
        check("bad_pulses", 32'(bad_seen - snap_bad), 32'd260);
        check("bad_cnt_sat", 32'(bad_cnt), 32'd255);
        check("bad_no_start", 32'(start_cnt - snap_start), 32'd0);
        check("bad_not_busy", 32'(busy), 32'd0);

        // Reset while capsule busy and sphere pending: all work discarded.
        res_ready = 1'b0;
        job_valid = 1'b1; job_type = 2'd0; job_id = 8'h77;
        cyc();
        job_valid = 1'b0;
        eng_done = 3'b001;
        cyc();
        eng_done = 3'b000;
        job_valid = 1'b1; job_type = 2'd2; job_id = 8'h88;
        cyc();
        job_valid = 1'b0;
        cyc();
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b0; #1;
        check_reset_outputs("midjob_reset_outputs");
        cycles(2);
        rst = 1'b1; res_ready = 1'b1;
        cycles(20);
        check("post_reset_no_result", 32'({res_valid, busy}), 32'd0);
        for (int t = 0; t < 4; t++) begin
            job_type = 2'(t); #1;
            check("post_reset_ready", 32'(job_ready), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/aabb_scheduler.md
AABB_SCHEDULER -- requirements
Module: aabb_scheduler

Interface
REQ-001 Parameter ID_W, default 8: job identifier width.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles an engine may stay BUSY before the job is aborted (range 1..65535).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 job_valid  input  1  a job is offered.
REQ-006 job_ready  output  1  the offered job can be accepted this cycle.
REQ-007 job_type  input  2  engine select: 0 sphere, 1 box, 2 capsule, 3 illegal.
REQ-008 job_id  input  ID_W  tag returned with the result.
REQ-009 eng_start  output  3  one-cycle start pulse per engine; bit0 sphere, bit1 box, bit2 capsule.
REQ-010 eng_done  input  3  one-cycle completion pulse per engine; engine holds its aabb0..aabb5 stable until its next eng_start.
REQ-011 res_valid  output  1  a result is presented.
REQ-012 res_ready  input  1  consumer takes the result.
REQ-013 res_type  output  2  engine that produced the result (0..2).
REQ-014 res_id  output  ID_W  job_id of that result.
REQ-015 res_err  output  1  result aborted by timeout; AABB data invalid.
REQ-016 bad_type  output  1  one-cycle pulse: an illegal-type job was accepted and dropped.
REQ-017 bad_cnt  output  8  saturating count of dropped illegal jobs.
REQ-018 busy  output  1  high while any engine is not IDLE.

Function
REQ-019 Each engine has an independent FSM with states IDLE, BUSY, PEND, plus a stored ID_W-bit id, an err flag and a 16-bit age counter.
REQ-020 job_ready is combinational: 1 if job_type==3, else 1 iff the selected engine is IDLE.
REQ-021 Acceptance = job_valid && job_ready; at that edge the engine goes IDLE->BUSY, stores job_id, clears err and age.
REQ-022 eng_start[t] is high for exactly the one cycle following acceptance; never high otherwise.
REQ-023 In BUSY, age increments by 1 per cycle; eng_done[t] moves BUSY->PEND with err=0.
REQ-024 In BUSY, age reaching TIMEOUT moves BUSY->PEND with err=1; if eng_done and timeout coincide, done wins (err=0).
REQ-025 eng_done on an engine in IDLE or PEND is ignored and changes no state.
REQ-026 Output arbiter: when res_valid is low, it selects a PEND engine round-robin starting from the engine after the last granted one (initial priority sphere, box, capsule) and raises res_valid on the next cycle with res_type/res_id/res_err from that engine.
REQ-027 While res_valid && !res_ready, res_valid/res_type/res_id/res_err hold stable and the selection does not change.
REQ-028 On res_valid && res_ready the granted engine goes PEND->IDLE, res_valid drops next cycle unless another engine is PEND, in which case the next result is presented with at most one cycle gap.
REQ-029 Freed engine's job_ready rises in the cycle after the result handshake; acceptance and handshake for different engines in the same cycle are both honoured.
REQ-030 Illegal job (type 3) accepted: no engine activity, bad_type pulses the following cycle, bad_cnt increments, saturating at 255.
REQ-031 busy = OR over engines of (state != IDLE).

Reset
REQ-032 While rst is low: all engines IDLE, ids/err/age 0, eng_start=0, res_valid=0, res_type=0, res_id=0, res_err=0, bad_type=0, bad_cnt=0, busy=0, round-robin pointer = sphere.
REQ-033 rst asserted mid-job aborts all jobs silently; no result is ever emitted for a job accepted before reset.

Verification
REQ-034 Sphere job id=0x11, engine done 5 cycles after eng_start[0], res_ready=1 -> eng_start=3'b001 one cycle, res_valid with res_type=0, res_id=0x11, res_err=0.
REQ-035 Sphere, box, capsule jobs ids 1,2,3 all done in the same cycle, res_ready=1 -> results delivered in order type 0,1,2 on consecutive handshakes.
REQ-036 Box job id=0x42, engine never done, TIMEOUT=8 -> res_valid with res_type=1, res_id=0x42, res_err=1 after age reaches 8; box job_ready 0 until handshake.
REQ-037 res_ready held low 10 cycles with result pending -> outputs stable all 10 cycles; second sphere job offered meanwhile sees job_ready=0.
REQ-038 260 type-3 jobs -> 260 bad_type pulses, bad_cnt=255, no eng_start pulse.
REQ-039 rst low while capsule BUSY and sphere PEND -> all outputs at reset values, no result after rst releases, all job_ready=1.
